// File: rtl/apb4_master_bridge.sv
// APB4 requester bridge: turns simple transfer requests into APB4 SETUP/ACCESS
// transfers on one of NUM_SLAVES slaves, with address decode and a wait-state timeout.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             transfer,
    output logic                             ack,
    input  logic                             SWRITE,
    input  logic [ADDR_WIDTH-1:0]            SADDR,
    input  logic [DATA_WIDTH-1:0]            SWDATA,
    input  logic [DATA_WIDTH/8-1:0]          SSTRB,
    input  logic [2:0]                       SPROT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    output logic [2:0]                       PPROT,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    output logic                             done,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic                             SLVERR,
    output logic                             TOUT,
    output logic                             busy
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [SEL_W:0] NUM_S    = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [7:0]     TOUT_LIM = 8'(TIMEOUT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DERR   = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [SEL_W-1:0]      idx_q, req_idx;
    logic                  req_miss;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [2:0]            prot_q;
    logic [7:0]            wait_cnt;

    logic                  in_access;
    logic                  sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timeout_hit;
    logic                  completing;

    // Slave index comes from the top address bits; indices past the last slave miss.
    always_comb begin
        req_idx  = (NUM_SLAVES == 1) ? '0 : SADDR[ADDR_WIDTH-1 -: SEL_W];
        req_miss = ({1'b0, req_idx} >= NUM_S);
    end

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_access   = (state == ST_ACCESS);
    assign timeout_hit = (TIMEOUT != 0) && in_access && !sel_ready && (wait_cnt == TOUT_LIM);
    assign completing  = in_access && (sel_ready || timeout_hit);
    assign ack         = PRESETn && transfer && ((state == ST_IDLE) || completing);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ack) state_nxt = req_miss ? ST_DERR : ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                // A request waiting at completion is taken without an IDLE bubble.
                if (completing) begin
                    if (ack) state_nxt = req_miss ? ST_DERR : ST_SETUP;
                    else     state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            // NOTE: captured request fields drive bus outputs directly, so they are reset too.
            idx_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prot_q   <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            RDATA    <= '0;
            SLVERR   <= 1'b0;
            TOUT     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ack) begin
                idx_q   <= req_idx;
                write_q <= SWRITE;
                addr_q  <= SADDR;
                wdata_q <= SWDATA;
                strb_q  <= SSTRB;
                prot_q  <= SPROT;
            end

            if (state == ST_SETUP)
                wait_cnt <= 8'd1;
            else if (in_access && !completing)
                wait_cnt <= wait_cnt + 8'd1;

            done <= completing || (state == ST_DERR);
            if (completing) begin
                RDATA  <= write_q ? '0 : sel_rdata;
                SLVERR <= (sel_ready && sel_err) || timeout_hit;
                TOUT   <= timeout_hit;
            end else if (state == ST_DERR) begin
                RDATA  <= '0;
                SLVERR <= 1'b1;
                TOUT   <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_SETUP) || in_access;

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            PSEL[i] = busy && (idx_q == SEL_W'(i));
    end

    // Data and strobes are forced to zero on reads; everything is zero outside a transfer.
    assign PENABLE = in_access;
    assign PWRITE  = busy && write_q;
    assign PADDR   = busy ? addr_q : '0;
    assign PWDATA  = (busy && write_q) ? wdata_q : '0;
    assign PSTRB   = (busy && write_q) ? strb_q : '0;
    assign PPROT   = busy ? prot_q : '0;

endmodule
